// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: ALU and memory/multiply result handshakes plus the
// register file write port and the busy flag.
// slave  : the arbiter side.
// master : the producer / register-file side (testbench, upstream stages).
interface writeback_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered
// memory/multiply results onto the single register file write port.
// ALU wins by default; a starvation counter forces the FIFO head through
// after STARVE_LIMIT consecutive passed-over cycles.
// Optional feature macro: WB_PERF_CNT_EN (adds perf_wr_cnt / perf_starve_cnt).
module writeback_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_arbiter_if.slave    bus
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_starve_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       fifo_rd   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;

  logic             busy_c;
  logic             starve_c;
  logic             push_c;
  logic             pop_c;
  logic             sel_alu_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [SC_W-1:0]  starve_nxt_c;

  // Handshake and arbitration decisions, all from registered state plus valids.
  always_comb begin
    busy_c       = (count != '0);
    starve_c     = busy_c && (starve_cnt == SC_W'(STARVE_LIMIT));
    push_c       = bus.mem_valid && (count != CNT_W'(DEPTH));
    sel_alu_c    = bus.alu_valid && !starve_c;
    pop_c        = !sel_alu_c && busy_c;
    count_nxt_c  = count + CNT_W'(push_c) - CNT_W'(pop_c);
    starve_nxt_c = starve_cnt;
    if (!busy_c || pop_c) begin
      starve_nxt_c = '0;
    end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
      starve_nxt_c = starve_cnt + SC_W'(1);
    end
  end

  assign bus.busy      = busy_c;
  assign bus.alu_ready = !starve_c;
  assign bus.mem_ready = (count != CNT_W'(DEPTH));

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_rd[wr_ptr]   <= bus.mem_rd;
      fifo_data[wr_ptr] <= bus.mem_data;
    end
  end

  // FIFO pointers, occupancy and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_nxt_c;
      starve_cnt <= starve_nxt_c;
    end
  end

  // Register file write port; address/data hold when nothing is selected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else if (sel_alu_c) begin
      bus.rf_we    <= (bus.alu_rd != 5'd0);
      bus.rf_waddr <= bus.alu_rd;
      bus.rf_wdata <= bus.alu_data;
    end else if (pop_c) begin
      bus.rf_we    <= (fifo_rd[rd_ptr] != 5'd0);
      bus.rf_waddr <= fifo_rd[rd_ptr];
      bus.rf_wdata <= fifo_data[rd_ptr];
    end else begin
      bus.rf_we    <= 1'b0;
    end
  end

`ifdef WB_PERF_CNT_EN
  // Performance counters: writes issued and cycles spent in forced-drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_wr_cnt     <= '0;
      perf_starve_cnt <= '0;
    end else begin
      if (bus.rf_we) perf_wr_cnt     <= perf_wr_cnt + 32'd1;
      if (starve_c)  perf_starve_cnt <= perf_starve_cnt + 32'd1;
    end
  end
`endif

endmodule
